// File: rtl/cpu_hazard_unit.sv
// cpu_hazard_unit
//   Operand forwarding and interlock control for the decode stage. Keeps a
//   scoreboard of the instructions in the NSTAGE stages after decode. For each
//   decode operand it picks the youngest in-flight producer. If that result is
//   already available, the unit forwards it. Otherwise it stalls fetch/decode
//   and inserts a bubble.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   i_dec_*             decoded instruction: valid, operand regs + use flags,
//                       destination write enable/reg, load flag
//   i_flush             kill the instruction currently in decode
//   i_stage_data        result at the output of each tracked stage
//   o_stall             hold PC/decode and insert a bubble
//   o_fwd_hit/sel/data  per-operand forward enable, source stage, value
//   o_stall_cnt         saturating count of stall cycles
module cpu_hazard_unit #(
    parameter int unsigned DW      = 16,
    parameter int unsigned NREG    = 8,
    parameter int unsigned NSTAGE  = 2,
    parameter int unsigned ALU_RDY = 0,
    parameter int unsigned LD_RDY  = 1,
    parameter int unsigned CNTW    = 16,
    localparam int unsigned RW     = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int unsigned SW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_dec_valid,
    input  logic [RW-1:0]                i_dec_rx,
    input  logic                         i_dec_rx_use,
    input  logic [RW-1:0]                i_dec_ry,
    input  logic                         i_dec_ry_use,
    input  logic                         i_dec_wr_en,
    input  logic [RW-1:0]                i_dec_rd,
    input  logic                         i_dec_is_load,
    input  logic                         i_flush,
    input  logic [NSTAGE-1:0][DW-1:0]    i_stage_data,
    output logic                         o_stall,
    output logic                         o_fwd_hit_a,
    output logic [SW-1:0]                o_fwd_sel_a,
    output logic [DW-1:0]                o_fwd_data_a,
    output logic                         o_fwd_hit_b,
    output logic [SW-1:0]                o_fwd_sel_b,
    output logic [DW-1:0]                o_fwd_data_b,
    output logic [CNTW-1:0]              o_stall_cnt
);

    if (!(ALU_RDY <= LD_RDY && LD_RDY < NSTAGE)) begin : g_bad_cfg
        $error("cpu_hazard_unit: require ALU_RDY <= LD_RDY < NSTAGE");
    end

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic [RW-1:0] rd;
        logic          is_load;
    } entry_t;

    entry_t [NSTAGE-1:0] entry_q, entry_d;
    logic   [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NSTAGE-1:0] match_a, match_b, ready;
    logic              found_a, found_b;
    logic              hazard_a, hazard_b;
    logic              hit_a, hit_b;
    logic [SW-1:0]     sel_a, sel_b;

    // Per-stage match and result-availability flags.
    always_comb begin
        match_a = '0;
        match_b = '0;
        ready   = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            match_a[k] = i_dec_valid && i_dec_rx_use && entry_q[k].valid &&
                         entry_q[k].wr_en && (entry_q[k].rd == i_dec_rx);
            match_b[k] = i_dec_valid && i_dec_ry_use && entry_q[k].valid &&
                         entry_q[k].wr_en && (entry_q[k].rd == i_dec_ry);
            ready[k]   = (k >= (entry_q[k].is_load ? LD_RDY : ALU_RDY));
        end
    end

    // Youngest match only: once found, older stages are ignored even when
    // the youngest producer is not ready yet (that is a hazard, not a miss).
    always_comb begin
        found_a  = 1'b0;
        found_b  = 1'b0;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (!found_a && match_a[k]) begin
                found_a = 1'b1;
                if (ready[k]) begin
                    hit_a = 1'b1;
                    sel_a = SW'(k);
                end else begin
                    hazard_a = 1'b1;
                end
            end
            if (!found_b && match_b[k]) begin
                found_b = 1'b1;
                if (ready[k]) begin
                    hit_b = 1'b1;
                    sel_b = SW'(k);
                end else begin
                    hazard_b = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_stall      = i_dec_valid && !i_flush && (hazard_a || hazard_b);
        o_fwd_hit_a  = hit_a;
        o_fwd_sel_a  = sel_a;
        o_fwd_data_a = hit_a ? i_stage_data[sel_a] : '0;
        o_fwd_hit_b  = hit_b;
        o_fwd_sel_b  = sel_b;
        o_fwd_data_b = hit_b ? i_stage_data[sel_b] : '0;
        o_stall_cnt  = stall_cnt_q;
    end

    // Scoreboard advance: decode enters stage 0 unless stalled or flushed;
    // downstream stages always shift.
    always_comb begin
        entry_d = '0;
        if (i_dec_valid && !o_stall && !i_flush) begin
            entry_d[0].valid   = 1'b1;
            entry_d[0].wr_en   = i_dec_wr_en;
            entry_d[0].rd      = i_dec_rd;
            entry_d[0].is_load = i_dec_is_load;
        end
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            entry_d[k] = entry_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            entry_q     <= entry_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// tb_cpu_hazard_unit
//   Bench for cpu_hazard_unit (NSTAGE=2, ALU_RDY=0, LD_RDY=1, CNTW=4).
//   Directed scenarios carry literal expectations; a reference model of the
//   in-flight instructions checks every cycle, including random traffic.
module tb_cpu_hazard_unit;

    localparam int DW      = 16;
    localparam int NREG    = 8;
    localparam int NSTAGE  = 2;
    localparam int ALU_RDY = 0;
    localparam int LD_RDY  = 1;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic                      clk;
    logic                      reset;
    logic                      dec_valid;
    logic [2:0]                dec_rx, dec_ry, dec_rd;
    logic                      dec_rx_use, dec_ry_use, dec_wr_en, dec_is_load;
    logic                      flush;
    logic [NSTAGE-1:0][DW-1:0] sd;
    logic                      stall;
    logic                      hit_a, hit_b;
    logic [0:0]                sel_a, sel_b;
    logic [DW-1:0]             data_a, data_b;
    logic [CNTW-1:0]           stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_hazard_unit #(
        .DW(DW), .NREG(NREG), .NSTAGE(NSTAGE),
        .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_dec_valid(dec_valid),
        .i_dec_rx(dec_rx), .i_dec_rx_use(dec_rx_use),
        .i_dec_ry(dec_ry), .i_dec_ry_use(dec_ry_use),
        .i_dec_wr_en(dec_wr_en), .i_dec_rd(dec_rd),
        .i_dec_is_load(dec_is_load), .i_flush(flush),
        .i_stage_data(sd),
        .o_stall(stall),
        .o_fwd_hit_a(hit_a), .o_fwd_sel_a(sel_a), .o_fwd_data_a(data_a),
        .o_fwd_hit_b(hit_b), .o_fwd_sel_b(sel_b), .o_fwd_data_b(data_b),
        .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pipe[a] = instruction issued a+1 cycles ago, i.e. now in stage a.
    typedef struct {
        bit v;
        bit wr;
        int rd;
        bit ld;
    } inst_t;

    inst_t pipe[NSTAGE];
    int    m_cnt;

    function automatic void model_clear();
        for (int a = 0; a < NSTAGE; a++) pipe[a] = '{0, 0, 0, 0};
        m_cnt = 0;
    endfunction

    function automatic void lookup(input int r, input bit u,
                                   output bit hit, output int sel, output bit haz);
        hit = 0; sel = 0; haz = 0;
        if (!(dec_valid && u)) return;
        for (int a = 0; a < NSTAGE; a++) begin
            if (pipe[a].v && pipe[a].wr && pipe[a].rd == r) begin
                // Stage a produces a usable value once it reaches the latency
                // of that instruction class.
                if (a >= (pipe[a].ld ? LD_RDY : ALU_RDY)) begin
                    hit = 1; sel = a;
                end else begin
                    haz = 1;
                end
                return;
            end
        end
    endfunction

    initial begin : compare_proc
        bit e_hit_a, e_hit_b, e_haz_a, e_haz_b, e_stall;
        int e_sel_a, e_sel_b;
        int e_dat_a, e_dat_b;
        model_clear();
        forever begin
            @(negedge clk);
            e_stall = 0;
            if (!reset) begin
                model_clear();
                chk("m_stall", {31'b0, stall}, 0);
                chk("m_hit_a", {31'b0, hit_a}, 0);
                chk("m_hit_b", {31'b0, hit_b}, 0);
                chk("m_data_a", {16'b0, data_a}, 0);
                chk("m_data_b", {16'b0, data_b}, 0);
                chk("m_cnt", {28'b0, stall_cnt}, 0);
            end else begin
                lookup(int'(dec_rx), dec_rx_use, e_hit_a, e_sel_a, e_haz_a);
                lookup(int'(dec_ry), dec_ry_use, e_hit_b, e_sel_b, e_haz_b);
                e_stall = dec_valid && !flush && (e_haz_a || e_haz_b);
                e_dat_a = e_hit_a ? int'(sd[e_sel_a]) : 0;
                e_dat_b = e_hit_b ? int'(sd[e_sel_b]) : 0;
                chk("m_stall", {31'b0, stall}, {31'b0, e_stall});
                chk("m_hit_a", {31'b0, hit_a}, {31'b0, e_hit_a});
                chk("m_sel_a", {31'b0, sel_a}, e_sel_a);
                chk("m_data_a", {16'b0, data_a}, e_dat_a);
                chk("m_hit_b", {31'b0, hit_b}, {31'b0, e_hit_b});
                chk("m_sel_b", {31'b0, sel_b}, e_sel_b);
                chk("m_data_b", {16'b0, data_b}, e_dat_b);
                chk("m_cnt", {28'b0, stall_cnt}, m_cnt);
            end
            @(posedge clk);
            if (!reset) begin
                model_clear();
            end else begin
                if (e_stall && m_cnt < CMAX) m_cnt++;
                for (int a = NSTAGE - 1; a > 0; a--) pipe[a] = pipe[a-1];
                if (dec_valid && !e_stall && !flush)
                    pipe[0] = '{1, dec_wr_en, int'(dec_rd), dec_is_load};
                else
                    pipe[0] = '{0, 0, 0, 0};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rx, input bit rxu, input int ry, input bit ryu,
                         input bit wr, input int rd, input bit ld, input bit fl);
        dec_valid   = v;
        dec_rx      = 3'(rx);
        dec_rx_use  = rxu;
        dec_ry      = 3'(ry);
        dec_ry_use  = ryu;
        dec_wr_en   = wr;
        dec_rd      = 3'(rd);
        dec_is_load = ld;
        flush       = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : stim
        reset = 1'b0;
        nop();
        sd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'b0, stall}, 0);
        chk("reset_cnt", {28'b0, stall_cnt}, 0);
        reset = 1'b1;

        // 1: ALU producer then consumer, forwarded from stage 0.
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);            // add r3
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);            // use r3 as A
        sd[0] = 16'h1234;
        @(negedge clk);
        chk("t1_hit_a", {31'b0, hit_a}, 1);
        chk("t1_sel_a", {31'b0, sel_a}, 0);
        chk("t1_data_a", {16'b0, data_a}, 32'h1234);
        chk("t1_stall", {31'b0, stall}, 0);
        step();
        nop();
        step();
        step();

        // 2: load-use costs one stall cycle.
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0);            // ld r2
        step();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0);            // use r2 as B
        @(negedge clk);
        chk("t2_stall", {31'b0, stall}, 1);
        chk("t2_hit_b0", {31'b0, hit_b}, 0);
        step();
        sd[1] = 16'hBEEF;
        @(negedge clk);
        chk("t2_hit_b", {31'b0, hit_b}, 1);
        chk("t2_sel_b", {31'b0, sel_b}, 1);
        chk("t2_data_b", {16'b0, data_b}, 32'hBEEF);
        chk("t2_stall2", {31'b0, stall}, 0);
        chk("t2_cnt", {28'b0, stall_cnt}, 1);
        step();
        nop();
        step();
        step();

        // 3: youngest producer wins over an older load.
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);            // ld r1
        step();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);            // mv r1
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);            // use r1 as A
        sd[0] = 16'h0005;
        sd[1] = 16'h7777;
        @(negedge clk);
        chk("t3_hit_a", {31'b0, hit_a}, 1);
        chk("t3_sel_a", {31'b0, sel_a}, 0);
        chk("t3_data_a", {16'b0, data_a}, 32'h0005);
        chk("t3_stall", {31'b0, stall}, 0);
        step();
        nop();
        step();
        step();

        // 4: flush beats the hazard and leaves no scoreboard entry.
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0);            // ld r2
        step();
        drive(1, 0, 0, 2, 1, 1, 5, 0, 1);            // use r2, writes r5, flushed
        @(negedge clk);
        chk("t4_stall", {31'b0, stall}, 0);
        step();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);            // r5 must not match
        @(negedge clk);
        chk("t4_hit_a", {31'b0, hit_a}, 0);
        chk("t4_cnt", {28'b0, stall_cnt}, 1);
        step();
        nop();
        step();
        step();

        // 5: asynchronous reset in the middle of a stall.
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0);
        step();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_stall_pre", {31'b0, stall}, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_stall", {31'b0, stall}, 0);
        chk("t5_hit_b", {31'b0, hit_b}, 0);
        chk("t5_cnt", {28'b0, stall_cnt}, 0);
        step();
        reset = 1'b1;
        nop();
        step();

        // 6: repeated self-dependent loads alternate stall/issue; counter saturates.
        drive(1, 4, 1, 0, 0, 1, 4, 1, 0);            // ld r4, [r4]
        repeat (40) step();
        @(negedge clk);
        chk("t6_cnt_sat", {28'b0, stall_cnt}, CMAX);
        step();
        nop();
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, NREG - 1), $urandom_range(0, 1) == 1,
                  $urandom_range(0, NREG - 1), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            sd[0] = 16'($urandom);
            sd[1] = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
            end
        end
        step();
        nop();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
